// File: rtl/mem_port_arbiter_pkg.sv
//==============================================================================
// mem_port_arbiter_pkg : shared types and defaults for the RAM port arbiter
// Rev 1.0
//==============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_D  = 1'b1
  } sel_e;

  localparam int DEF_RD_LAT         = 1;
  localparam int DEF_MAX_DATA_BURST = 4;

  // Bits needed for a counter that must reach max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// mem_port_arbiter_if : requester handshakes and RAM bus of the port arbiter
// Rev 1.0
//==============================================================================
`default_nettype none

interface mem_port_arbiter_if;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;

  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic        busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  data_i,
    output if_ack_o, if_rdata_o,
    output d_ack_o, d_rdata_o,
    output we_o, addr_o, data_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output data_i,
    input  if_ack_o, if_rdata_o,
    input  d_ack_o, d_rdata_o,
    input  we_o, addr_o, data_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
//==============================================================================
// mem_arb_pick : grant decision between fetch and data plus burst guard counter
// Rev 1.0
//==============================================================================
`default_nettype none

module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic grant_o,
  output sel_e sel_o
);

  localparam int               CNT_W = cnt_width(MAX_DATA_BURST);
  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_DATA_BURST);

  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;
  logic             w_guard_met;
  logic             w_pick_if;

  // Data normally wins; fetch only wins a collision once the guard is met.
  assign w_guard_met = (burst_cnt_q == c_MAX);
  assign w_pick_if   = if_req_i & (~d_req_i | w_guard_met);
  assign grant_o     = idle_i & (if_req_i | d_req_i);
  assign sel_o       = w_pick_if ? SEL_IF : SEL_D;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (idle_i) begin
      if (!if_req_i || w_pick_if) begin
        burst_cnt_d = '0;
      end else if (d_req_i && !w_guard_met) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// mem_port_arbiter : shares one RAM port between fetch and load/store requesters
// Rev 1.0
//==============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT         = DEF_RD_LAT,
  parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
  localparam logic [1:0] c_ST_ACCESS = ST_ACCESS;
  localparam logic [1:0] c_ST_DONE   = ST_DONE;

  localparam int               LAT_W      = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] c_LAT_LAST = LAT_W'(RD_LAT);

  logic [1:0]       state_q,    state_d;
  sel_e             sel_q,      sel_d;
  logic             wr_q,       wr_d;
  logic [LAT_W-1:0] lat_q,      lat_d;
  logic [31:0]      addr_q,     addr_d;
  logic [31:0]      data_q,     data_d;
  logic             we_q,       we_d;
  logic             if_ack_q,   if_ack_d;
  logic             d_ack_q,    d_ack_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q,  d_rdata_d;
  logic             busy_q,     busy_d;

  logic             w_idle;
  logic             w_grant;
  sel_e             w_sel;
  logic             w_grant_wr;

  assign w_idle = (state_q == c_ST_IDLE);

  mem_arb_pick #(
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .idle_i   (w_idle),
    .if_req_i (bus.if_req_i),
    .d_req_i  (bus.d_req_i),
    .grant_o  (w_grant),
    .sel_o    (w_sel)
  );

  assign w_grant_wr = (w_sel == SEL_D) & bus.d_we_i;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      c_ST_IDLE: begin
        if (w_grant) begin
          sel_d   = w_sel;
          wr_d    = w_grant_wr;
          addr_d  = (w_sel == SEL_D) ? bus.d_addr_i : bus.if_addr_i;
          if (w_grant_wr) begin
            data_d = bus.d_wdata_i;
          end
          we_d    = w_grant_wr;
          lat_d   = LAT_W'(1);
          state_d = c_ST_ACCESS;
        end
      end
      c_ST_ACCESS: begin
        if (wr_q) begin
          if_ack_d = (sel_q == SEL_IF);
          d_ack_d  = (sel_q == SEL_D);
          state_d  = c_ST_DONE;
        end else if (lat_q == c_LAT_LAST) begin
          // RAM data is only valid on the last latency cycle.
          if (sel_q == SEL_IF) begin
            if_rdata_d = bus.data_i;
          end else begin
            d_rdata_d  = bus.data_i;
          end
          if_ack_d = (sel_q == SEL_IF);
          d_ack_d  = (sel_q == SEL_D);
          state_d  = c_ST_DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase

    busy_d = (state_d != c_ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= c_ST_IDLE;
      sel_q      <= SEL_IF;
      wr_q       <= 1'b0;
      lat_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.we_o       = we_q;
  assign bus.addr_o     = addr_q;
  assign bus.data_o     = data_q;
  assign bus.if_ack_o   = if_ack_q;
  assign bus.d_ack_o    = d_ack_q;
  assign bus.if_rdata_o = if_rdata_q;
  assign bus.d_rdata_o  = d_rdata_q;
  assign bus.busy_o     = busy_q;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single RAM port (`we_o`, `addr_o`, `data_o`, `data_i`) between the instruction-fetch requester and the load/store data requester. It sits between the control/fetch logic and RAM. Each requester gets a req/ack handshake, and the arbiter sequences each access through a small state machine that accounts for a fixed RAM read latency. Data accesses have priority, and a bounded-burst guard keeps fetch from starving.

## Interface
- `RD_LAT`, default 1: ACCESS cycles from address presentation to `data_i` being sampled (≥1).
- `MAX_DATA_BURST`, default 4: consecutive data grants allowed while fetch waits (≥1).
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `if_req_i` in 1: fetch request; held with `if_addr_i` stable until `if_ack_o`.
- `if_addr_i` in 32: fetch address.
- `if_ack_o` out 1: one-cycle completion pulse for fetch.
- `if_rdata_o` out 32: fetched word; valid with `if_ack_o`, held until the next fetch ack.
- `d_req_i` in 1: data request; `d_we_i`, `d_addr_i` and `d_wdata_i` are held stable until `d_ack_o`.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_addr_i` in 32: data address.
- `d_wdata_i` in 32: store data.
- `d_ack_o` out 1: one-cycle completion pulse for data.
- `d_rdata_o` out 32: load word; valid with `d_ack_o`, held until the next data ack. Unchanged by stores.
- `we_o` out 1: RAM write enable.
- `addr_o` out 32: RAM address.
- `data_o` out 32: RAM write data.
- `data_i` in 32: RAM read data.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:** arbitrate among the asserted requests.
  - Grant fetch if only `if_req_i` is high, or if both are high and `burst_cnt == MAX_DATA_BURST`.
  - Otherwise grant data if `d_req_i` is high.
  - On a grant, latch the port select, address, write data and write flag, then go to ACCESS.
- **ACCESS (read):** `addr_o` is driven from the latch and `we_o` is 0.
  - The latency counter counts 1..RD_LAT.
  - On the RD_LAT-th cycle, sample `data_i` into the granted port's rdata register and go to DONE.
- **ACCESS (write):** lasts exactly one cycle with `we_o`=1 and `addr_o`/`data_o` driven from the latch, then go to DONE.
- **DONE:** pulse the granted port's ack, then return to IDLE.
- **burst_cnt** (width holds MAX_DATA_BURST):
  - Increments on a data grant while `if_req_i` is high.
  - Clears on a fetch grant, or on any IDLE cycle with `if_req_i` low.
  - Saturates at MAX_DATA_BURST.
- **Requester rule:** a requester changes `req` or its inputs only in the cycle after its ack. A req still high in the IDLE cycle after DONE is a new request.
- **Outputs outside ACCESS:** `we_o`=0; `addr_o` and `data_o` hold their last values.

## Timing
- **Read:** req sampled in IDLE at cycle T; `addr_o` is valid at cycles T+1..T+RD_LAT; ack at T+RD_LAT+1. Next grant is possible at T+RD_LAT+2.
- **Write:** req at T; `we_o` is high only at T+1; ack at T+2.
- Acks are registered, mutually exclusive, and never high for two consecutive cycles.
- **Simultaneous requests in IDLE:** data wins unless the burst guard is met. The loser stays pending with no ack.
- **Reset** (`reset`=0, at any time including mid-ACCESS): state goes to IDLE immediately.
  - `we_o`, `if_ack_o`, `d_ack_o`, `busy_o` and `burst_cnt` = 0.
  - `addr_o`, `data_o`, `if_rdata_o` and `d_rdata_o` = 0.
  - An in-flight write is aborted with no ack.
- **Outputs:** all registered, with no combinational path from any input to any output.

## Structure
- **Shared package:** state enum (IDLE/ACCESS/DONE), port-select enum (SEL_IF/SEL_D), and the default RD_LAT and MAX_DATA_BURST constants.
- **Sub-module `mem_arb_pick`:** holds the combinational grant decision plus the `burst_cnt` register. The FSM, latches and latency counter stay in `mem_port_arbiter`.

## Test plan
- **Fetch read:** RD_LAT=1; `if_req_i`=1, `if_addr_i`=0x100; RAM returns 0xDEADBEEF. Expect `addr_o`=0x100 at T+1, `if_ack_o` at T+2 with `if_rdata_o`=0xDEADBEEF, and `we_o` never high.
- **Store:** `d_req_i`=1, `d_we_i`=1, `d_addr_i`=0x40, `d_wdata_i`=0x12345678. Expect `we_o`=1 only at T+1 with `addr_o`=0x40 and `data_o`=0x12345678, `d_ack_o` at T+2, and `d_rdata_o` unchanged.
- **Collision:** both requests rise in the same cycle. Expect data served first and fetch acked on the following access, with fetch never acked before data.
- **Starvation guard:** MAX_DATA_BURST=4; `if_req_i` held high; data re-requests back-to-back. Expect exactly 4 data acks, then a fetch ack, then data resumes.
- **Read latency:** RD_LAT=3; load from 0x80. Expect `addr_o` stable for 3 cycles, `data_i` sampled on the third, and `d_ack_o` at T+4.
- **Reset mid-write:** assert `reset`=0 during the write ACCESS cycle. Expect `we_o` and `busy_o` to drop asynchronously, no ack, and a clean new grant once reset is released.
